// File: rtl/uart_tx_fifo.sv
// Write-buffered UART transmit queue: bus byte writes land in a FIFO and a
// drain FSM polls the UART core status and feeds its TX data register.
module uart_tx_fifo #(
  parameter int         DEPTH            = 16,
  parameter int         ADDR_WIDTH       = 4,
  parameter logic [3:0] UART_TXDATA_ADDR = 4'h0,
  parameter logic [3:0] UART_STATUS_ADDR = 4'h4,
  parameter int         UART_BUSY_BIT    = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  data_req_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic [31:0]           data_wdata_i,
  output logic [31:0]           data_rdata_o,
  output logic                  uart_en_o,
  output logic                  uart_wen_o,
  output logic [3:0]            uart_addr_o,
  output logic [31:0]           uart_wdata_o,
  input  logic [31:0]           uart_rdata_i
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {IDLE, POLL, CHECK, WRITE, HOLD} state_t;

  state_t         state, nxt;
  logic [7:0]     mem [DEPTH];
  logic [PW-1:0]  rd_ptr, wr_ptr;
  logic [CW-1:0]  count;
  logic           ovf;
  logic [3:0]     reg_addr;
  logic           full, empty, push_req, push_ok, drop, pop, flush, clr_ovf, st_rd;
  logic [31:0]    status;
  logic           unused_bits;

  assign reg_addr   = data_addr_i[3:0];
  assign data_gnt_o = data_req_i & en_i;
  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);

  assign push_req = data_gnt_o & data_we_i & (reg_addr == 4'h0) & data_be_i[0];
  assign flush    = data_gnt_o & data_we_i & (reg_addr == 4'h8) & data_wdata_i[1];
  assign clr_ovf  = data_gnt_o & data_we_i & (reg_addr == 4'h8) & data_wdata_i[0];
  assign st_rd    = data_gnt_o & ~data_we_i & (reg_addr == 4'h4);
  assign pop      = (state == WRITE);
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok  = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  assign status      = {16'b0, 8'(count), 5'b0, ovf, empty, full};
  assign unused_bits = ^{data_be_i[3:1], data_wdata_i[31:8], uart_rdata_i};

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= data_wdata_i[7:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (pop)     rd_ptr <= rd_ptr + 1'b1;
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (push_ok && !pop)      count <= count + 1'b1;
        else if (!push_ok && pop) count <= count - 1'b1;
      end
      if (clr_ovf)   ovf <= 1'b0;
      else if (drop) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_rvalid_o <= 1'b0;
      data_rdata_o  <= '0;
    end else begin
      data_rvalid_o <= data_gnt_o;
      data_rdata_o  <= st_rd ? status : 32'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (!empty) nxt = POLL;
      // Bailing out on empty also covers a flush that landed while in IDLE.
      POLL:  nxt = (flush || empty) ? IDLE : CHECK;
      CHECK: begin
        if (flush || empty)              nxt = IDLE;
        else if (uart_rdata_i[UART_BUSY_BIT]) nxt = POLL;
        else                             nxt = WRITE;
      end
      WRITE: nxt = HOLD;
      // Skip the idle cycle when more bytes wait, keeping 4 cycles per byte.
      HOLD:  nxt = empty ? IDLE : POLL;
      default: nxt = IDLE;
    endcase
  end

  // UART strobes are registered from the next state so they align with it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      uart_en_o    <= 1'b0;
      uart_wen_o   <= 1'b0;
      uart_addr_o  <= '0;
      uart_wdata_o <= '0;
    end else begin
      uart_en_o   <= (nxt == POLL) || (nxt == WRITE);
      uart_wen_o  <= (nxt == WRITE);
      uart_addr_o <= (nxt == POLL)  ? UART_STATUS_ADDR :
                     (nxt == WRITE) ? UART_TXDATA_ADDR : 4'h0;
      if (nxt == WRITE) uart_wdata_o <= {24'b0, mem[rd_ptr]};
    end
  end
endmodule
